// File: rtl/ex_stage_mc_pkg.sv
// rtl/ex_stage_mc_pkg.sv - shared encodings for the execute stage
// Purpose: operation class bit positions, sub-op encodings, flag bit
//          positions, multiplier FSM state codes and a one-hot helper.
// Ports:   none (package).
package ex_stage_mc_pkg;

  // Bit positions inside dopc_i (one-hot class select)
  localparam int DOPC_INTE  = 3;
  localparam int DOPC_SHIFT = 2;
  localparam int DOPC_LOGIC = 1;
  localparam int DOPC_MUL   = 0;

  // INTE sub-ops
  localparam logic [2:0] OPC_ADD  = 3'd0;
  localparam logic [2:0] OPC_SUB  = 3'd1;
  localparam logic [2:0] OPC_MOV  = 3'd2;
  localparam logic [2:0] OPC_CMP  = 3'd3;
  // SHIFT sub-ops
  localparam logic [2:0] OPC_SLL  = 3'd0;
  localparam logic [2:0] OPC_SRL  = 3'd1;
  localparam logic [2:0] OPC_SRA  = 3'd2;
  localparam logic [2:0] OPC_ROTL = 3'd3;
  // LOGIC sub-ops
  localparam logic [2:0] OPC_AND  = 3'd0;
  localparam logic [2:0] OPC_OR   = 3'd1;
  localparam logic [2:0] OPC_XOR  = 3'd2;
  localparam logic [2:0] OPC_NOT  = 3'd3;
  // MUL sub-ops
  localparam logic [2:0] OPC_MUL  = 3'd0;

  // Flag bit positions in flags_o
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Multiplier FSM states
  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_BUSY = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

  function automatic logic onehot4(input logic [3:0] x);
    return (x != 4'd0) && ((x & (x - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// rtl/ex_mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
// Purpose: low WORD bits of a_i*b_i (unsigned) after WORD BUSY cycles.
// Ports:   clk, rst (async, active-low)
//          start_i  latch operands and begin (honoured in IDLE only)
//          abort_i  return to IDLE immediately, overrides everything
//          ack_i    consumer takes the product while in DONE
//          a_i/b_i  operands; busy_o = not IDLE; done_o = product ready; prod_o
module ex_mul_iter
  import ex_stage_mc_pkg::*;
#(
  parameter int WORD = 16,
  parameter int W_SH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            ack_i,
  input  logic [WORD-1:0] a_i,
  input  logic [WORD-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [WORD-1:0] prod_o
);

  logic [1:0]      state_q, state_d;
  logic [W_SH-1:0] cnt_q, cnt_d;
  logic [WORD-1:0] acc_q, acc_d;
  logic [WORD-1:0] mcand_q, mcand_d;
  logic [WORD-1:0] mplier_q, mplier_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      MUL_IDLE: if (start_i) begin
        acc_d    = '0;
        mcand_d  = a_i;
        mplier_d = b_i;
        cnt_d    = '0;
        state_d  = MUL_BUSY;
      end
      MUL_BUSY: begin
        // Bits shifted past WORD are dropped: only the low word is kept.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + W_SH'(1);
        if (cnt_q == W_SH'(WORD - 1)) state_d = MUL_DONE;
      end
      MUL_DONE: if (ack_i) state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
    if (abort_i) state_d = MUL_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy_o = (state_q != MUL_IDLE);
  assign done_o = (state_q == MUL_DONE);
  assign prod_o = acc_q;

endmodule

// File: rtl/ex_stage_mc.sv
// rtl/ex_stage_mc.sv - execute stage with single-cycle ALU and iterative multiply
// Purpose: executes INTE/SHIFT/LOGIC ops in one cycle, MUL over WORD+1 cycles,
//          with valid/stall handshakes on both sides and a flags register.
// Ports:   clk, rst (async, active-low), flush_i (sync abort)
//          ID side: v_i, stall_o, dopc_i, opc_i, src_i, dest_i, wb_i, setf_i, rd_num_i
//          WB side: stall_i, v_o, wb_o, rd_num_o, rd_data_o, flags_o {Z,N,C,V}
module ex_stage_mc
  import ex_stage_mc_pkg::*;
#(
  parameter int WORD = 16,
  parameter int W_RD = 3,
  parameter int W_SH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            v_i,
  output logic            stall_o,
  input  logic [3:0]      dopc_i,
  input  logic [2:0]      opc_i,
  input  logic [WORD-1:0] src_i,
  input  logic [WORD-1:0] dest_i,
  input  logic            wb_i,
  input  logic            setf_i,
  input  logic [W_RD-1:0] rd_num_i,
  input  logic            stall_i,
  output logic            v_o,
  output logic            wb_o,
  output logic [W_RD-1:0] rd_num_o,
  output logic [WORD-1:0] rd_data_o,
  output logic [3:0]      flags_o
);

  // Single-cycle ALU: returns {result, Z, N, C, V}; undefined sub-ops give 0.
  function automatic logic [WORD+3:0] alu_f(input logic [3:0] cls, input logic [2:0] opc,
                                             input logic [WORD-1:0] d, input logic [WORD-1:0] s);
    logic [WORD-1:0] r;
    logic [WORD:0]   t;
    logic [W_SH-1:0] amt;
    logic [3:0]      fl;
    logic            c, v;
    r = '0; t = '0; c = 1'b0; v = 1'b0;
    amt = s[W_SH-1:0];
    if (cls[DOPC_INTE]) begin
      case (opc)
        OPC_ADD: begin
          t = {1'b0, d} + {1'b0, s};
          r = t[WORD-1:0];
          c = t[WORD];
          v = (d[WORD-1] == s[WORD-1]) && (r[WORD-1] != d[WORD-1]);
        end
        OPC_SUB, OPC_CMP: begin
          r = d - s;
          c = (d >= s);
          v = (d[WORD-1] != s[WORD-1]) && (r[WORD-1] != d[WORD-1]);
        end
        OPC_MOV: r = s;
        default: r = '0;
      endcase
    end else if (cls[DOPC_SHIFT]) begin
      // The extra guard bit in t catches the last bit shifted out; it stays 0 for amount 0.
      case (opc)
        OPC_SLL: begin
          t = {1'b0, d} << amt;
          r = t[WORD-1:0];
          c = t[WORD];
        end
        OPC_SRL: begin
          t = {d, 1'b0} >> amt;
          r = t[WORD:1];
          c = t[0];
        end
        OPC_SRA: begin
          t = $signed({d, 1'b0}) >>> amt;
          r = t[WORD:1];
          c = t[0];
        end
        OPC_ROTL: begin
          r = (d << amt) | (d >> (WORD - int'(amt)));
          c = (amt != '0) && r[0];
        end
        default: r = '0;
      endcase
    end else if (cls[DOPC_LOGIC]) begin
      case (opc)
        OPC_AND: r = d & s;
        OPC_OR:  r = d | s;
        OPC_XOR: r = d ^ s;
        OPC_NOT: r = ~d;
        default: r = '0;
      endcase
    end
    fl[FLAG_Z] = (r == '0);
    fl[FLAG_N] = r[WORD-1];
    fl[FLAG_C] = c;
    fl[FLAG_V] = v;
    return {r, fl};
  endfunction

  logic            v_q, v_d, wb_q, wb_d;
  logic [W_RD-1:0] rd_q, rd_d, mrd_q, mrd_d;
  logic [WORD-1:0] data_q, data_d;
  logic [3:0]      flags_q, flags_d;
  logic            mwb_q, mwb_d, msetf_q, msetf_d;

  logic            adv, accept, cls_ok, is_mul, alu_def, is_cmp;
  logic [WORD+3:0] alu_bus;
  logic            mul_busy, mul_done;
  logic [WORD-1:0] mul_prod;

  assign adv     = ~(v_q & stall_i);
  assign stall_o = (v_q & stall_i) | mul_busy;
  assign accept  = v_i & ~stall_o & ~flush_i;
  assign cls_ok  = onehot4(dopc_i);
  assign is_mul  = cls_ok & dopc_i[DOPC_MUL] & (opc_i == OPC_MUL);
  assign alu_def = cls_ok & ~dopc_i[DOPC_MUL] & (opc_i <= 3'd3);
  assign is_cmp  = cls_ok & dopc_i[DOPC_INTE] & (opc_i == OPC_CMP);
  assign alu_bus = alu_f(dopc_i, opc_i, dest_i, src_i);

  ex_mul_iter #(.WORD(WORD), .W_SH(W_SH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept & is_mul),
    .abort_i (flush_i),
    .ack_i   (adv),
    .a_i     (dest_i),
    .b_i     (src_i),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  always_comb begin
    v_d     = v_q;
    wb_d    = wb_q;
    rd_d    = rd_q;
    data_d  = data_q;
    flags_d = flags_q;
    mrd_d   = mrd_q;
    mwb_d   = mwb_q;
    msetf_d = msetf_q;
    if (flush_i) begin
      v_d  = 1'b0;
      wb_d = 1'b0;
    end else if (adv) begin
      if (mul_done) begin
        v_d    = 1'b1;
        wb_d   = mwb_q;
        rd_d   = mrd_q;
        data_d = mul_prod;
        if (msetf_q) begin
          flags_d         = 4'd0;
          flags_d[FLAG_Z] = (mul_prod == '0);
          flags_d[FLAG_N] = mul_prod[WORD-1];
        end
      end else if (accept && !is_mul) begin
        // Covers NOP (bad dopc) and undefined sub-ops: valid passes, data 0.
        v_d    = 1'b1;
        wb_d   = wb_i & cls_ok & ~is_cmp;
        rd_d   = rd_num_i;
        data_d = alu_def ? alu_bus[WORD+3:4] : '0;
        if (setf_i && alu_def) flags_d = alu_bus[3:0];
      end else begin
        v_d  = 1'b0;
        wb_d = 1'b0;
      end
    end
    if (accept && is_mul) begin
      mrd_d   = rd_num_i;
      mwb_d   = wb_i;
      msetf_d = setf_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q     <= 1'b0;
      wb_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      flags_q <= 4'd0;
      mrd_q   <= '0;
      mwb_q   <= 1'b0;
      msetf_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      mrd_q   <= mrd_d;
      mwb_q   <= mwb_d;
      msetf_q <= msetf_d;
    end
  end

  assign v_o       = v_q;
  assign wb_o      = wb_q;
  assign rd_num_o  = rd_q;
  assign rd_data_o = data_q;
  assign flags_o   = flags_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// tb/tb_ex_stage_mc.sv - directed-vector bench for ex_stage_mc at WORD=16
module tb_ex_stage_mc;

  logic        clk = 1'b0, rst = 1'b0, flush_i = 1'b0, v_i = 1'b0, stall_i = 1'b0;
  logic        wb_i = 1'b0, setf_i = 1'b0;
  logic [3:0]  dopc_i = 4'd0;
  logic [2:0]  opc_i = 3'd0, rd_num_i = 3'd0;
  logic [15:0] src_i = 16'd0, dest_i = 16'd0;
  logic        stall_o, v_o, wb_o;
  logic [2:0]  rd_num_o;
  logic [15:0] rd_data_o;
  logic [3:0]  flags_o;

  int nvec = 0;
  int nerr = 0;

  ex_stage_mc #(.WORD(16), .W_RD(3), .W_SH(4)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .v_i(v_i), .stall_o(stall_o),
    .dopc_i(dopc_i), .opc_i(opc_i), .src_i(src_i), .dest_i(dest_i), .wb_i(wb_i),
    .setf_i(setf_i), .rd_num_i(rd_num_i), .stall_i(stall_i), .v_o(v_o), .wb_o(wb_o),
    .rd_num_o(rd_num_o), .rd_data_o(rd_data_o), .flags_o(flags_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  dopc;
    logic [2:0]  opc;
    logic [15:0] d;
    logic [15:0] s;
    logic        wb;
    logic        setf;
    logic [2:0]  rd;
    logic [15:0] xd;
    logic [3:0]  xf;
    logic        xwb;
    logic        chk;
  } vec_t;

  vec_t vt [16];

  task automatic set_op(input logic [3:0] dopc, input logic [2:0] opc, input logic [15:0] d,
                        input logic [15:0] s, input logic wb, input logic setf, input logic [2:0] rd);
    dopc_i = dopc; opc_i = opc; dest_i = d; src_i = s;
    wb_i = wb; setf_i = setf; rd_num_i = rd; v_i = 1'b1;
  endtask

  task automatic drive(input logic [3:0] dopc, input logic [2:0] opc, input logic [15:0] d,
                       input logic [15:0] s, input logic wb, input logic setf, input logic [2:0] rd);
    @(negedge clk);
    set_op(dopc, opc, d, s, wb, setf, rd);
    @(posedge clk); #1;
    v_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    set_op(4'b1000, 3'd0, 16'h0001, 16'h0001, 1'b1, 1'b1, 3'd1);
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if ({v_o, wb_o, stall_o} !== 3'b000) begin
      nerr++; $display("FAIL reset_ctrl: got v/wb/stall=%b want 000", {v_o, wb_o, stall_o});
    end
    nvec++;
    if ({rd_num_o, rd_data_o, flags_o} !== 23'd0) begin
      nerr++; $display("FAIL reset_data: got rd=%h data=%h flags=%b want 0", rd_num_o, rd_data_o, flags_o);
    end
    v_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_alu;
    vt = '{
      '{4'b1000, 3'd0, 16'h7FFF, 16'h0001, 1'b1, 1'b1, 3'd1, 16'h8000, 4'b0101, 1'b1, 1'b1},
      '{4'b1000, 3'd3, 16'h0005, 16'h0005, 1'b1, 1'b1, 3'd2, 16'h0000, 4'b1010, 1'b0, 1'b1},
      '{4'b0100, 3'd2, 16'h8000, 16'h0003, 1'b1, 1'b1, 3'd3, 16'hF000, 4'b0100, 1'b1, 1'b1},
      '{4'b1000, 3'd1, 16'h8000, 16'h0001, 1'b1, 1'b1, 3'd4, 16'h7FFF, 4'b0011, 1'b1, 1'b1},
      '{4'b0100, 3'd0, 16'h8001, 16'h0001, 1'b1, 1'b1, 3'd5, 16'h0002, 4'b0010, 1'b1, 1'b1},
      '{4'b0100, 3'd1, 16'h0003, 16'h0010, 1'b1, 1'b1, 3'd6, 16'h0003, 4'b0000, 1'b1, 1'b1},
      '{4'b0100, 3'd1, 16'h0003, 16'h0001, 1'b1, 1'b1, 3'd7, 16'h0001, 4'b0010, 1'b1, 1'b1},
      '{4'b0100, 3'd3, 16'h8001, 16'h0001, 1'b1, 1'b1, 3'd1, 16'h0003, 4'b0010, 1'b1, 1'b1},
      '{4'b0010, 3'd0, 16'hF0F0, 16'h0FF0, 1'b1, 1'b1, 3'd2, 16'h00F0, 4'b0000, 1'b1, 1'b1},
      '{4'b0010, 3'd2, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 3'd3, 16'h0000, 4'b1000, 1'b1, 1'b1},
      '{4'b1000, 3'd0, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 3'd4, 16'h0000, 4'b1010, 1'b1, 1'b1},
      '{4'b0010, 3'd3, 16'h00FF, 16'h0000, 1'b1, 1'b1, 3'd5, 16'hFF00, 4'b0100, 1'b1, 1'b1},
      '{4'b1000, 3'd2, 16'h0000, 16'h1234, 1'b1, 1'b0, 3'd6, 16'h1234, 4'b0100, 1'b1, 1'b1},
      '{4'b1000, 3'd5, 16'h1111, 16'h2222, 1'b0, 1'b1, 3'd7, 16'h0000, 4'b0100, 1'b0, 1'b1},
      '{4'b0110, 3'd0, 16'h1111, 16'h2222, 1'b1, 1'b1, 3'd0, 16'h0000, 4'b0100, 1'b0, 1'b0},
      '{4'b0010, 3'd1, 16'h00F0, 16'h0F00, 1'b1, 1'b1, 3'd1, 16'h0FF0, 4'b0000, 1'b1, 1'b1}
    };
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].dopc, vt[i].opc, vt[i].d, vt[i].s, vt[i].wb, vt[i].setf, vt[i].rd);
      nvec++;
      if ({v_o, wb_o} !== {1'b1, vt[i].xwb}) begin
        nerr++; $display("FAIL alu_vwb[%0d]: got v=%b wb=%b want v=1 wb=%b", i, v_o, wb_o, vt[i].xwb);
      end
      nvec++;
      if (flags_o !== vt[i].xf) begin
        nerr++; $display("FAIL alu_flags[%0d]: got %b want %b", i, flags_o, vt[i].xf);
      end
      if (vt[i].chk) begin
        nvec++;
        if (rd_data_o !== vt[i].xd || rd_num_o !== vt[i].rd) begin
          nerr++; $display("FAIL alu_data[%0d]: got data=%h rd=%0d want data=%h rd=%0d",
                           i, rd_data_o, rd_num_o, vt[i].xd, vt[i].rd);
        end
      end
    end
  endtask

  task automatic test_mul;
    drive(4'b0001, 3'd0, 16'h0123, 16'h0010, 1'b1, 1'b1, 3'd5);
    nvec++;
    if ({stall_o, v_o} !== 2'b10) begin
      nerr++; $display("FAIL mul_start: got stall=%b v=%b want stall=1 v=0", stall_o, v_o);
    end
    for (int k = 1; k < 17; k++) begin
      @(posedge clk); #1;
      nvec++;
      if ({stall_o, v_o} !== 2'b10) begin
        nerr++; $display("FAIL mul_busy[%0d]: got stall=%b v=%b want stall=1 v=0", k, stall_o, v_o);
      end
    end
    @(posedge clk); #1;
    nvec++;
    if ({v_o, wb_o, stall_o, rd_num_o, rd_data_o, flags_o} !== {1'b1, 1'b1, 1'b0, 3'd5, 16'h1230, 4'b0000}) begin
      nerr++; $display("FAIL mul_result: got v=%b wb=%b stall=%b rd=%0d data=%h flags=%b want 1 1 0 5 1230 0000",
                       v_o, wb_o, stall_o, rd_num_o, rd_data_o, flags_o);
    end
  endtask

  task automatic test_back_to_back;
    drive(4'b1000, 3'd0, 16'h0001, 16'h0002, 1'b1, 1'b1, 3'd2);
    stall_i = 1'b1;
    set_op(4'b1000, 3'd0, 16'h000A, 16'h0014, 1'b1, 1'b1, 3'd3);
    #1;
    nvec++;
    if (stall_o !== 1'b1) begin
      nerr++; $display("FAIL bp_stall_o: got %b want 1", stall_o);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      nvec++;
      if ({v_o, stall_o, rd_num_o, rd_data_o} !== {1'b1, 1'b1, 3'd2, 16'h0003}) begin
        nerr++; $display("FAIL bp_hold[%0d]: got v=%b stall=%b rd=%0d data=%h want 1 1 2 0003",
                         k, v_o, stall_o, rd_num_o, rd_data_o);
      end
    end
    stall_i = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if ({v_o, rd_num_o, rd_data_o} !== {1'b1, 3'd3, 16'h001E}) begin
      nerr++; $display("FAIL bp_release: got v=%b rd=%0d data=%h want 1 3 001E", v_o, rd_num_o, rd_data_o);
    end
    v_i = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if (v_o !== 1'b0) begin
      nerr++; $display("FAIL bp_bubble: got v=%b want 0", v_o);
    end
    stall_i = 1'b1;
    set_op(4'b1000, 3'd0, 16'h0004, 16'h0004, 1'b1, 1'b1, 3'd4);
    #1;
    nvec++;
    if (stall_o !== 1'b0) begin
      nerr++; $display("FAIL bubble_stall_o: got %b want 0", stall_o);
    end
    @(posedge clk); #1;
    nvec++;
    if ({v_o, rd_num_o, rd_data_o} !== {1'b1, 3'd4, 16'h0008}) begin
      nerr++; $display("FAIL bubble_accept: got v=%b rd=%0d data=%h want 1 4 0008", v_o, rd_num_o, rd_data_o);
    end
    v_i = 1'b0;
    stall_i = 1'b0;
  endtask

  task automatic test_flush;
    logic seen_v;
    drive(4'b0010, 3'd2, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 3'd1);
    drive(4'b0001, 3'd0, 16'h00FF, 16'h0003, 1'b1, 1'b1, 3'd6);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    nvec++;
    if ({stall_o, v_o} !== 2'b00) begin
      nerr++; $display("FAIL flush_now: got stall=%b v=%b want 00", stall_o, v_o);
    end
    seen_v = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (v_o) seen_v = 1'b1;
    end
    nvec++;
    if (seen_v !== 1'b0) begin
      nerr++; $display("FAIL flush_no_product: got v_o pulse=%b want 0", seen_v);
    end
    nvec++;
    if ({flags_o, stall_o} !== {4'b1000, 1'b0}) begin
      nerr++; $display("FAIL flush_flags: got flags=%b stall=%b want 1000 0", flags_o, stall_o);
    end
  endtask

  task automatic test_reset_mid_mul;
    logic seen_v;
    drive(4'b0010, 3'd3, 16'h00FF, 16'h0000, 1'b1, 1'b1, 3'd2);
    drive(4'b0001, 3'd0, 16'h0123, 16'h0010, 1'b1, 1'b1, 3'd5);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    nvec++;
    if ({v_o, wb_o, stall_o, rd_num_o, rd_data_o, flags_o} !== 26'd0) begin
      nerr++; $display("FAIL rst_async: got v=%b wb=%b stall=%b rd=%0d data=%h flags=%b want all 0",
                       v_o, wb_o, stall_o, rd_num_o, rd_data_o, flags_o);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(4'b1000, 3'd0, 16'h0002, 16'h0003, 1'b1, 1'b1, 3'd7);
    nvec++;
    if ({v_o, wb_o, rd_num_o, rd_data_o, flags_o} !== {1'b1, 1'b1, 3'd7, 16'h0005, 4'b0000}) begin
      nerr++; $display("FAIL rst_add_after: got v=%b wb=%b rd=%0d data=%h flags=%b want 1 1 7 0005 0000",
                       v_o, wb_o, rd_num_o, rd_data_o, flags_o);
    end
    @(posedge clk); #1;
    seen_v = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (v_o || stall_o) seen_v = 1'b1;
    end
    nvec++;
    if (seen_v !== 1'b0) begin
      nerr++; $display("FAIL rst_no_product: got activity=%b want 0", seen_v);
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_mul;
    test_back_to_back;
    test_flush;
    test_reset_mid_mul;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
